hex_byte_decoder: RTL and testbench

- Receive-side stage that sits directly downstream of the serial receive FIFO.
- Pops ASCII characters from the FIFO and decodes pairs of hex digits into binary bytes.
- Presents each decoded byte to a consumer (command logic or the UART transmitter) through a strobe/ready handshake.
- Tracks line boundaries and reports per-line byte count and error status.

---
 rtl/hex_byte_decoder.sv | 169 ++++++++++++++++
 tb/tb_hex_byte_decoder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/hex_byte_decoder.sv
// Receive-side stage that pops ASCII characters from the serial RX FIFO and turns pairs of hex digits
// into bytes. It hands each byte to a consumer with a strobe/ready handshake and reports line ends.
module hex_byte_decoder #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             in_data,
    input  logic                   in_available,
    output logic                   in_strobe,
    output logic [7:0]             out_data,
    output logic                   out_strobe,
    input  logic                   out_ready,
    output logic                   line_strobe,
    output logic                   line_error,
    output logic [COUNT_WIDTH-1:0] byte_count
);

    typedef enum logic [1:0] {
        NIBBLE_HI,
        NIBBLE_LO,
        OUT_WAIT
    } state_t;

    typedef enum logic [1:0] {
        CLS_HEX,
        CLS_SPACE,
        CLS_EOL,
        CLS_BAD
    } char_class_t;

    state_t                 state_q, state_d;
    logic [3:0]             hi_q, hi_d;
    logic                   err_q, err_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;

    logic                   in_strobe_d;
    logic [7:0]             out_data_d;
    logic                   out_strobe_d;
    logic                   line_strobe_d;
    logic                   line_error_d;
    logic [COUNT_WIDTH-1:0] byte_count_d;

    char_class_t            char_class;
    logic [3:0]             char_nibble;

    // Character classification and hex-digit value of the FIFO head.
    always_comb begin
        char_class  = CLS_BAD;
        char_nibble = 4'h0;
        if (in_data >= 8'h30 && in_data <= 8'h39) begin
            char_class  = CLS_HEX;
            char_nibble = 4'(in_data - 8'h30);
        end else if (in_data >= 8'h61 && in_data <= 8'h66) begin
            char_class  = CLS_HEX;
            char_nibble = 4'(in_data - 8'h57);
        end else if (in_data >= 8'h41 && in_data <= 8'h46) begin
            char_class  = CLS_HEX;
            char_nibble = 4'(in_data - 8'h37);
        end else if (in_data == 8'h20 || in_data == 8'h09) begin
            char_class  = CLS_SPACE;
        end else if (in_data == 8'h0A || in_data == 8'h0D) begin
            char_class  = CLS_EOL;
        end
    end

    // Next-state and next-output logic; a character only acts in its in_strobe cycle.
    always_comb begin
        state_d       = state_q;
        hi_d          = hi_q;
        err_d         = err_q;
        count_d       = count_q;
        out_data_d    = out_data;
        out_strobe_d  = 1'b0;
        line_strobe_d = 1'b0;
        line_error_d  = line_error;
        byte_count_d  = byte_count;
        in_strobe_d   = in_available && (state_q != OUT_WAIT) && !in_strobe;

        unique case (state_q)
            NIBBLE_HI: begin
                if (in_strobe) begin
                    unique case (char_class)
                        CLS_HEX: begin
                            hi_d    = char_nibble;
                            state_d = NIBBLE_LO;
                        end
                        CLS_SPACE: ;
                        CLS_BAD: err_d = 1'b1;
                        CLS_EOL: begin
                            line_strobe_d = 1'b1;
                            line_error_d  = err_q;
                            byte_count_d  = count_q;
                            err_d         = 1'b0;
                            count_d       = '0;
                            hi_d          = 4'h0;
                        end
                        default: ;
                    endcase
                end
            end

            NIBBLE_LO: begin
                if (in_strobe) begin
                    unique case (char_class)
                        CLS_HEX: begin
                            out_data_d = {hi_q, char_nibble};
                            state_d    = OUT_WAIT;
                        end
                        CLS_SPACE, CLS_BAD: begin
                            err_d   = 1'b1;
                            hi_d    = 4'h0;
                            state_d = NIBBLE_HI;
                        end
                        CLS_EOL: begin
                            // A dangling high nibble makes the ending line erroneous.
                            line_strobe_d = 1'b1;
                            line_error_d  = 1'b1;
                            byte_count_d  = count_q;
                            err_d         = 1'b0;
                            count_d       = '0;
                            hi_d          = 4'h0;
                            state_d       = NIBBLE_HI;
                        end
                        default: ;
                    endcase
                end
            end

            OUT_WAIT: begin
                if (out_ready && !out_strobe) begin
                    out_strobe_d = 1'b1;
                    count_d      = (count_q == {COUNT_WIDTH{1'b1}}) ? count_q : count_q + 1'b1;
                    state_d      = NIBBLE_HI;
                end
            end

            default: state_d = NIBBLE_HI;
        endcase
    end

    // State and registered outputs; reset drops any partial or pending byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= NIBBLE_HI;
            hi_q        <= 4'h0;
            err_q       <= 1'b0;
            count_q     <= '0;
            in_strobe   <= 1'b0;
            out_data    <= 8'h00;
            out_strobe  <= 1'b0;
            line_strobe <= 1'b0;
            line_error  <= 1'b0;
            byte_count  <= '0;
        end else begin
            state_q     <= state_d;
            hi_q        <= hi_d;
            err_q       <= err_d;
            count_q     <= count_d;
            in_strobe   <= in_strobe_d;
            out_data    <= out_data_d;
            out_strobe  <= out_strobe_d;
            line_strobe <= line_strobe_d;
            line_error  <= line_error_d;
            byte_count  <= byte_count_d;
        end
    end

endmodule

// File: tb/tb_hex_byte_decoder.sv
// Directed bench for hex_byte_decoder: a queue models the RX FIFO, a negedge monitor records
// delivered bytes and line reports, and each test compares them against hand-computed values.
module tb_hex_byte_decoder;

    logic        clk;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_available;
    logic        in_strobe;
    logic [7:0]  out_data;
    logic        out_strobe;
    logic        out_ready;
    logic        line_strobe;
    logic        line_error;
    logic [15:0] byte_count;

    int totalChecks = 0;
    int badChecks   = 0;

    logic [7:0]  fifoQ[$];
    logic [7:0]  gotBytes[$];
    logic [16:0] gotLines[$];
    int          popCount    = 0;
    int          consecPops  = 0;
    int          bothStrobes = 0;
    logic        prevPop     = 1'b0;

    hex_byte_decoder #(.COUNT_WIDTH(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_available (in_available),
        .in_strobe    (in_strobe),
        .out_data     (out_data),
        .out_strobe   (out_strobe),
        .out_ready    (out_ready),
        .line_strobe  (line_strobe),
        .line_error   (line_error),
        .byte_count   (byte_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model: pops at the edge ending an in_strobe cycle, head refreshes on the next negedge.
    always @(posedge clk) begin
        if (in_strobe && fifoQ.size() > 0) begin
            void'(fifoQ.pop_front());
            popCount++;
        end
    end

    always @(negedge clk) begin
        in_available = (fifoQ.size() > 0);
        in_data      = (fifoQ.size() > 0) ? fifoQ[0] : 8'h00;
        if (reset) begin
            if (out_strobe) gotBytes.push_back(out_data);
            if (line_strobe) gotLines.push_back({line_error, byte_count});
            if (in_strobe && prevPop) consecPops++;
            if (out_strobe && line_strobe) bothStrobes++;
        end
        prevPop = in_strobe;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        totalChecks++;
        if (got !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input string s);
        for (int i = 0; i < s.len(); i++) fifoQ.push_back(s[i]);
    endtask

    task automatic runCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clearLog();
        gotBytes.delete();
        gotLines.delete();
    endtask

    function automatic logic [31:0] byteAt(input int i);
        return (gotBytes.size() > i) ? {24'h0, gotBytes[i]} : 32'hDEAD;
    endfunction

    function automatic logic [31:0] lineAt(input int i);
        return (gotLines.size() > i) ? {15'h0, gotLines[i]} : 32'hDEAD;
    endfunction

    initial begin
        int startPops;
        int waitCycles;

        reset        = 1'b0;
        out_ready    = 1'b1;
        in_data      = 8'h00;
        in_available = 1'b0;
        runCycles(3);
        checkOutput("reset_outputs", {in_strobe, out_strobe, line_strobe, line_error, out_data, byte_count},
                    32'h0);
        reset = 1'b1;
        runCycles(2);

        $display("[TB] test 1: 3A LF");
        clearLog();
        applyStimulus("3A\n");
        runCycles(20);
        checkOutput("t1_nbytes", gotBytes.size(), 1);
        checkOutput("t1_byte0", byteAt(0), 32'h3A);
        checkOutput("t1_nlines", gotLines.size(), 1);
        checkOutput("t1_line0", lineAt(0), {15'h0, 1'b0, 16'd1});

        $display("[TB] test 2: de AD CR LF");
        clearLog();
        applyStimulus("de AD\r\n");
        runCycles(40);
        checkOutput("t2_nbytes", gotBytes.size(), 2);
        checkOutput("t2_byte0", byteAt(0), 32'hDE);
        checkOutput("t2_byte1", byteAt(1), 32'hAD);
        checkOutput("t2_nlines", gotLines.size(), 2);
        checkOutput("t2_line0", lineAt(0), {15'h0, 1'b0, 16'd2});
        checkOutput("t2_line1", lineAt(1), 32'h0);

        $display("[TB] test 3: 3G LF");
        clearLog();
        applyStimulus("3G\n");
        runCycles(20);
        checkOutput("t3_nbytes", gotBytes.size(), 0);
        checkOutput("t3_nlines", gotLines.size(), 1);
        checkOutput("t3_line0", lineAt(0), {15'h0, 1'b1, 16'd0});

        $display("[TB] test 4: partial nibbles");
        clearLog();
        applyStimulus("4\n4 1\n");
        runCycles(30);
        checkOutput("t4_nbytes", gotBytes.size(), 0);
        checkOutput("t4_nlines", gotLines.size(), 2);
        checkOutput("t4_line0", lineAt(0), {15'h0, 1'b1, 16'd0});
        checkOutput("t4_line1", lineAt(1), {15'h0, 1'b1, 16'd0});

        $display("[TB] test 5: consumer stall");
        clearLog();
        out_ready = 1'b0;
        startPops = popCount;
        applyStimulus("1234\n");
        runCycles(100);
        checkOutput("t5_stall_nbytes", gotBytes.size(), 0);
        checkOutput("t5_stall_data", out_data, 32'h12);
        checkOutput("t5_stall_pops", popCount - startPops, 2);
        out_ready = 1'b1;
        runCycles(30);
        checkOutput("t5_nbytes", gotBytes.size(), 2);
        checkOutput("t5_byte0", byteAt(0), 32'h12);
        checkOutput("t5_byte1", byteAt(1), 32'h34);
        checkOutput("t5_line0", lineAt(0), {15'h0, 1'b0, 16'd2});

        $display("[TB] test 6: reset mid-byte");
        clearLog();
        startPops  = popCount;
        waitCycles = 0;
        applyStimulus("5");
        while (popCount == startPops && waitCycles < 50) begin
            @(negedge clk);
            waitCycles++;
        end
        checkOutput("t6_pop_seen", (popCount != startPops), 1);
        @(posedge clk);
        #1 reset = 1'b0;
        runCycles(3);
        checkOutput("t6_reset_outputs",
                    {in_strobe, out_strobe, line_strobe, line_error, out_data, byte_count}, 32'h0);
        reset = 1'b1;
        runCycles(2);
        applyStimulus("67\n");
        runCycles(20);
        checkOutput("t6_nbytes", gotBytes.size(), 1);
        checkOutput("t6_byte0", byteAt(0), 32'h67);
        checkOutput("t6_line0", lineAt(0), {15'h0, 1'b0, 16'd1});

        checkOutput("back_to_back_pops", consecPops, 0);
        checkOutput("strobe_overlap", bothStrobes, 0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
